dmem: RTL
=========

Name: dmem

Overview:
- Word-organised data memory that answers the CPU's data-memory interface: chip select, read strobe, write strobe, 11-bit byte address, 32-bit write data, 32-bit read data.
- Reads are combinational, so a load completes in the same cycle, as the single-cycle CPU requires.
- Writes commit on the rising clock edge.
- Adds sticky protocol-error flags and optional access counters for debug.

Parameters:
- ADDR_W, 11, byte-address width of DM_addr.
- DEPTH, 512, number of 32-bit words; must equal 2**(ADDR_W-2).
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- DM_cs  in  1  chip select; no access occurs when low.
- DM_R  in  1  read strobe (qualified by DM_cs).
- DM_W  in  1  write strobe (qualified by DM_cs).
- DM_addr  in  ADDR_W  byte address; word index = DM_addr[ADDR_W-1:2].
- DM_data_in  in  32  write data.
- DM_data_out  out  32  read data.
- err_misalign  out  1  sticky: an access was attempted with DM_addr[1:0] != 0.
- err_conflict  out  1  sticky: DM_R and DM_W were both high with DM_cs.
- rd_cnt  out  CNT_W  count of completed reads.
- wr_cnt  out  CNT_W  count of committed writes.

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and on its release:
  - all DEPTH words = 0
  - err_misalign = 0, err_conflict = 0
  - rd_cnt = 0, wr_cnt = 0
  - a reset asserted mid-write cancels that write; the word stays 0.
- Define idx = DM_addr[ADDR_W-1:2] and aligned = (DM_addr[1:0] == 2'b00).
- Read path (combinational, zero latency):
  - DM_data_out = mem[idx] when DM_cs & DM_R & aligned; otherwise DM_data_out = 32'h0.
  - A read in the same cycle as a write to the same word returns the old contents. No forwarding.
- Write path: at posedge clk, when DM_cs & DM_W & !DM_R & aligned & !rst, mem[idx] <= DM_data_in. The new value is visible to reads in the next cycle.
- Misaligned access (DM_cs & (DM_R|DM_W) & !aligned):
  - the write is dropped and the read returns 0
  - err_misalign is set at the next posedge and held until reset.
- Conflict (DM_cs & DM_R & DM_W):
  - the write is suppressed; the read proceeds normally, subject to alignment
  - err_conflict is set at the next posedge and held until reset.
- DM_cs=0: the strobes are ignored, DM_data_out=0, and no flag or counter changes.
- Counters:
  - rd_cnt increments at the posedge of each cycle with a valid aligned read.
  - wr_cnt increments on each committed write.
  - Both saturate at all-ones and never wrap.
- Address space: idx covers exactly DEPTH words; there is no wrap and no out-of-range case at the defaults.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: rd_cnt and wr_cnt are live, as described under Behaviour.
- Undefined: counter registers are not built; rd_cnt and wr_cnt are tied to 0. Ports remain so the interface is unchanged.
- Error flags and memory behaviour are identical in both builds.

Test Plan:
- Reset then read: rst pulse; cs=1, R=1, addr=0x000 and addr=0x7FC -> DM_data_out=0x00000000, both flags 0, counters 0.
- Write then read: cs=1, W=1, addr=0x010, data=0xDEADBEEF; next cycle cs=1, R=1, addr=0x010 -> DM_data_out=0xDEADBEEF. With DMEM_STATS_EN: wr_cnt=1, rd_cnt=1 after that edge.
- Misaligned write: cs=1, W=1, addr=0x012, data=0x12345678, then read 0x010 -> still 0xDEADBEEF. err_misalign=1 and stays 1 for 10 further idle cycles.
- Conflict: cs=1, R=1, W=1, addr=0x010, data=0x0 -> same-cycle DM_data_out=0xDEADBEEF. Next cycle the read still returns 0xDEADBEEF; err_conflict=1.
- cs gating: cs=0, W=1, addr=0x020, data=0xAAAA5555, then cs=1, R=1, addr=0x020 -> 0x00000000. No flags set; wr_cnt unchanged.
- Async reset mid-operation: write 0x1 to 0x040; assert rst between edges -> flags, counters and DM_data_out clear immediately without a clock edge. Read 0x040 after release -> 0x00000000. With DMEM_STATS_EN and CNT_W=2, 5 writes -> wr_cnt=3 (saturated).

Source files
------------

// File: rtl/dmem.sv
// Word-organised data memory with combinational read, clocked write, sticky protocol-error flags
// and optional saturating access counters (enabled by defining DMEM_STATS_EN).
module dmem #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_cs,
    input  logic              DM_R,
    input  logic              DM_W,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [31:0]       DM_data_in,
    output logic [31:0]       DM_data_out,
    output logic              err_misalign,
    output logic              err_conflict,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    logic [ADDR_W-3:0] idx;
    logic              aligned;
    logic              access;
    logic              rd_ok;
    logic              wr_ok;
    logic              conflict;
    logic [31:0]       mem [DEPTH];

    always_comb begin
        idx      = DM_addr[ADDR_W-1:2];
        aligned  = (DM_addr[1:0] == 2'b00);
        access   = DM_cs & (DM_R | DM_W);
        conflict = DM_cs & DM_R & DM_W;
        rd_ok    = DM_cs & DM_R & aligned;
        // a simultaneous read wins; the write side of a conflict is dropped
        wr_ok    = DM_cs & DM_W & ~DM_R & aligned;
    end

    // Every word is a resettable register so that reset leaves the memory fully zeroed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[idx] <= DM_data_in;
        end
    end

    // Read returns the pre-write contents in a same-cycle read/write; there is no forwarding.
    always_comb begin
        DM_data_out = 32'h0;
        if (rd_ok) begin
            DM_data_out = mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_misalign <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            if (access && !aligned) begin
                err_misalign <= 1'b1;
            end
            if (conflict) begin
                err_conflict <= 1'b1;
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;

    // Both counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_ok && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (wr_ok && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule
